vga_pmod_capture: RTL and testbench

// - Receive side of the Tiny VGA PMOD: samples the 8 uo_out pins, decodes sync and colour,

---
 rtl/vga_capture_pkg.sv | 37 +++
 rtl/vga_pmod_capture_if.sv | 20 ++
 rtl/vga_pmod_decode.sv | 41 ++++
 rtl/vga_pmod_capture.sv | 158 +++++++++++++++
 tb/tb_vga_pmod_capture.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_capture_pkg.sv
// Shared timing defaults, PMOD pin indices and FSM states
// for the Tiny VGA PMOD capture block.
package vga_capture_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D  = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D  = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 33;

  localparam int PIN_R1 = 0;
  localparam int PIN_G1 = 1;
  localparam int PIN_B1 = 2;
  localparam int PIN_VS = 3;
  localparam int PIN_R0 = 4;
  localparam int PIN_G0 = 5;
  localparam int PIN_B0 = 6;
  localparam int PIN_HS = 7;

  typedef enum logic [1:0] {
    SEARCH,
    WAIT_FRAME,
    LOCKED
  } cap_state_e;

  function automatic int h_total(int a, int f, int s, int b);
    return a + f + s + b;
  endfunction

  function automatic int v_total(int a, int f, int s, int b);
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/vga_pmod_capture_if.sv
// Captured pixel stream: coordinates, colour and
// line/frame start markers.
interface vga_pmod_capture_if;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [5:0] pix_rgb;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pix_valid, pix_x, pix_y, pix_rgb,
    output line_start, frame_start
  );

  modport slave (
    input pix_valid, pix_x, pix_y, pix_rgb,
    input line_start, frame_start
  );
endinterface

// File: rtl/vga_pmod_decode.sv
// Stage 1: register PMOD pins, unmap colour, resolve
// sync polarity and detect sync assertion edges.
module vga_pmod_decode
  import vga_capture_pkg::*;
#(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pmod_in,
  output logic [5:0] rgb,
  output logic       hs_edge,
  output logic       vs_edge
);

  logic hs_q, vs_q;
  logic hs_p, vs_p;

  // Sync is held as "asserted", so reset reads as idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hs_p <= 1'b0;
      vs_p <= 1'b0;
    end else begin
      rgb  <= {pmod_in[PIN_R1], pmod_in[PIN_R0],
               pmod_in[PIN_G1], pmod_in[PIN_G0],
               pmod_in[PIN_B1], pmod_in[PIN_B0]};
      hs_q <= (pmod_in[PIN_HS] == SYNC_POL);
      vs_q <= (pmod_in[PIN_VS] == SYNC_POL);
      hs_p <= hs_q;
      vs_p <= vs_q;
    end
  end

  assign hs_edge = hs_q & ~hs_p;
  assign vs_edge = vs_q & ~vs_p;

endmodule

// File: rtl/vga_pmod_capture.sv
// Tiny VGA PMOD receiver: timing recovery, pixel
// coordinates, lock tracking and length checks.
module vga_pmod_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FRONT  = H_FRONT_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BACK   = H_BACK_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FRONT  = V_FRONT_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BACK   = V_BACK_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [7:0]          pmod_in,
  vga_pmod_capture_if.master  pix,
  output logic                locked,
  output logic                err_hlen,
  output logic                err_vlen,
  output logic [10:0]         line_len,
  output logic [9:0]          frame_lines
);

  localparam logic [10:0] H_TOT =
    11'(h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
  localparam logic [9:0] V_TOT =
    10'(v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
  localparam logic [10:0] H_LO = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_HI = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  V_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_HI = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

  logic [5:0]  rgb_q;
  logic        hs_edge, vs_edge;
  logic [10:0] hcount, h_inc, h_cur;
  logic [9:0]  vcount, v_inc, v_cur;
  logic        in_win, h_err, v_err;
  logic        h_seen, v_seen;
  cap_state_e  state, state_n;
  logic        armed, armed_n;
  logic        err_seen, err_seen_n;

  vga_pmod_decode #(.SYNC_POL(SYNC_POL)) u_dec (
    .clk     (clk),
    .rst     (rst),
    .pmod_in (pmod_in),
    .rgb     (rgb_q),
    .hs_edge (hs_edge),
    .vs_edge (vs_edge)
  );

  // Counts describe the stage-1 sample; both saturate
  always_comb begin
    h_inc  = (hcount == 11'h7FF) ? hcount : hcount + 11'd1;
    v_inc  = (vcount == 10'h3FF) ? vcount : vcount + 10'd1;
    h_cur  = hs_edge ? 11'd0 : h_inc;
    v_cur  = vs_edge ? 10'd0 : (hs_edge ? v_inc : vcount);
    in_win = (h_cur >= H_LO) && (h_cur <= H_HI) &&
             (v_cur >= V_LO) && (v_cur <= V_HI);
    h_err  = en && hs_edge && h_seen && (h_inc != H_TOT);
    v_err  = en && vs_edge && v_seen && (v_inc != V_TOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      armed    <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      state    <= state_n;
      armed    <= armed_n;
      err_seen <= err_seen_n;
    end
  end

  // armed: a frame boundary has opened the clean-frame check
  always_comb begin
    state_n    = state;
    armed_n    = armed;
    err_seen_n = err_seen;
    if (!en) begin
      state_n = SEARCH;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vs_edge) begin
            state_n    = WAIT_FRAME;
            armed_n    = 1'b1;
            err_seen_n = 1'b0;
          end
        end
        WAIT_FRAME: begin
          if (vs_edge) begin
            if (armed && !err_seen && !h_err && !v_err) begin
              state_n = LOCKED;
            end else begin
              armed_n    = 1'b1;
              err_seen_n = 1'b0;
            end
          end else if (h_err || v_err) begin
            err_seen_n = 1'b1;
          end
        end
        LOCKED: begin
          if (h_err || v_err) begin
            state_n    = WAIT_FRAME;
            armed_n    = 1'b0;
            err_seen_n = 1'b0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount          <= '0;
      vcount          <= '0;
      h_seen          <= 1'b0;
      v_seen          <= 1'b0;
      line_len        <= '0;
      frame_lines     <= '0;
      locked          <= 1'b0;
      err_hlen        <= 1'b0;
      err_vlen        <= 1'b0;
      pix.pix_valid   <= 1'b0;
      pix.pix_x       <= '0;
      pix.pix_y       <= '0;
      pix.pix_rgb     <= '0;
      pix.line_start  <= 1'b0;
      pix.frame_start <= 1'b0;
    end else begin
      hcount <= h_cur;
      vcount <= v_cur;
      h_seen <= en && (h_seen || hs_edge);
      v_seen <= en && (v_seen || vs_edge);
      if (hs_edge) line_len <= h_inc;
      if (vs_edge) frame_lines <= v_inc;
      locked          <= (state_n == LOCKED);
      err_hlen        <= h_err;
      err_vlen        <= v_err;
      pix.line_start  <= en && hs_edge;
      pix.frame_start <= en && vs_edge;
      pix.pix_valid   <= en && in_win && (state_n == LOCKED);
      if (in_win) begin
        pix.pix_x   <= 10'(h_cur - H_LO);
        pix.pix_y   <= v_cur - V_LO;
        pix.pix_rgb <= rgb_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Randomised-colour bench for vga_pmod_capture on a
// shrunken video mode with a frame-level reference model.
module tb_vga_pmod_capture;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX = HA * VA;

  typedef struct {
    logic       ls;
    logic       fs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] rgb;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  pmod_in;
  logic        locked, err_hlen, err_vlen;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  vga_pmod_capture_if pif ();

  vga_pmod_capture #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pmod_in     (pmod_in),
    .pix         (pif),
    .locked      (locked),
    .err_hlen    (err_hlen),
    .err_vlen    (err_vlen),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t h0, h1;
  int   nv;
  int   pv_cnt, errh_cnt, errv_cnt;
  logic [10:0] errh_len;
  logic [9:0]  errv_lines;
  logic        fs_locked;
  logic [5:0]  probe_rgb;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pins_of(logic [5:0] rgb,
                                         logic hs, logic vs);
    logic [7:0] p;
    p[0] = rgb[5];
    p[4] = rgb[4];
    p[1] = rgb[3];
    p[5] = rgb[2];
    p[2] = rgb[1];
    p[6] = rgb[0];
    p[3] = ~vs;
    p[7] = ~hs;
    return p;
  endfunction

  task automatic clear_stats();
    pv_cnt     = 0;
    errh_cnt   = 0;
    errv_cnt   = 0;
    errh_len   = 'x;
    errv_lines = 'x;
    fs_locked  = 1'bx;
    probe_rgb  = 'x;
  endtask

  // Outputs at this negedge belong to the sample driven two negedges ago
  task automatic step(input logic [7:0] pins, input ent_t e);
    @(negedge clk);
    if (nv >= 2) begin
      chk("line_start", pif.line_start, h1.ls);
      chk("frame_start", pif.frame_start, h1.fs);
      if (pif.pix_valid) begin
        chk("pix_win", pif.pix_valid, h1.act);
        chk("pix_x", pif.pix_x, h1.x);
        chk("pix_y", pif.pix_y, h1.y);
        chk("pix_rgb", pif.pix_rgb, h1.rgb);
      end
    end
    if (pif.pix_valid) pv_cnt++;
    if (pif.pix_valid && pif.pix_x == 0 && pif.pix_y == 0)
      probe_rgb = pif.pix_rgb;
    if (err_hlen) begin
      errh_cnt++;
      errh_len = line_len;
    end
    if (err_vlen) begin
      errv_cnt++;
      errv_lines = frame_lines;
    end
    if (pif.frame_start) fs_locked = locked;
    h1 = h0;
    h0 = e;
    nv++;
    pmod_in = pins;
  endtask

  task automatic gen_frame(input int nlines, input int short_line,
                           input bit probe);
    ent_t e;
    logic [5:0] rgb;
    bit hs, vs, act;
    int len;
    clear_stats();
    for (int v = 0; v < nlines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        hs  = (h < HS);
        vs  = (v < VS);
        act = (h >= HS + HB) && (h < HS + HB + HA) &&
              (v >= VS + VB) && (v < VS + VB + VA);
        rgb = act ? 6'($urandom) : 6'd0;
        if (probe && act && h == HS + HB && v == VS + VB)
          rgb = 6'b100000;
        e.ls  = (h == 0) && en;
        e.fs  = (h == 0) && (v == 0) && en;
        e.act = act;
        e.x   = 10'(h - HS - HB);
        e.y   = 10'(v - VS - VB);
        e.rgb = rgb;
        step(pins_of(rgb, hs, vs), e);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, pif.pix_valid, 0);
    chk({tag, "_x"}, pif.pix_x, 0);
    chk({tag, "_y"}, pif.pix_y, 0);
    chk({tag, "_rgb"}, pif.pix_rgb, 0);
    chk({tag, "_ls"}, pif.line_start, 0);
    chk({tag, "_fs"}, pif.frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_errh"}, err_hlen, 0);
    chk({tag, "_errv"}, err_vlen, 0);
    chk({tag, "_llen"}, line_len, 0);
    chk({tag, "_flines"}, frame_lines, 0);
  endtask

  initial begin
    ent_t idle;
    idle = '{ls: 1'b0, fs: 1'b0, act: 1'b0, x: '0, y: '0, rgb: '0};
    h0 = idle;
    h1 = idle;
    nv = 0;
    rst = 1'b1;
    en = 1'b1;
    pmod_in = 8'hFF;
    clear_stats();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    nv = 0;

    gen_frame(VT, -1, 0);
    chk("f1_pv", pv_cnt, 0);
    chk("f1_lock", fs_locked, 0);
    gen_frame(VT, -1, 0);
    chk("f2_lock", fs_locked, 1);
    chk("f2_pv", pv_cnt, NPIX);
    gen_frame(VT, -1, 0);
    chk("f3_pv", pv_cnt, NPIX);
    chk("f3_llen", line_len, HT);
    chk("f3_flines", frame_lines, VT);
    chk("f3_errh", errh_cnt, 0);
    chk("f3_errv", errv_cnt, 0);
    chk("f3_locked", locked, 1);

    gen_frame(VT, -1, 1);
    chk("probe_rgb", probe_rgb, 6'b100000);
    chk("f4_pv", pv_cnt, NPIX);

    gen_frame(VT, 3, 0);
    chk("short_errh", errh_cnt, 1);
    chk("short_llen", errh_len, HT - 1);
    chk("short_locked", locked, 0);
    chk("short_pv", pv_cnt, 0);
    gen_frame(VT, -1, 0);
    chk("f6_lock", fs_locked, 0);
    chk("f6_pv", pv_cnt, 0);
    gen_frame(VT, -1, 0);
    chk("f7_lock", fs_locked, 1);
    chk("f7_pv", pv_cnt, NPIX);

    gen_frame(VT - 1, -1, 0);
    chk("f8_pv", pv_cnt, NPIX);
    chk("f8_errv", errv_cnt, 0);
    gen_frame(VT, -1, 0);
    chk("f9_errv", errv_cnt, 1);
    chk("f9_flines", errv_lines, VT - 1);
    chk("f9_lock", fs_locked, 0);
    chk("f9_pv", pv_cnt, 0);

    en = 1'b0;
    gen_frame(VT, -1, 0);
    chk("en0_pv", pv_cnt, 0);
    chk("en0_locked", locked, 0);
    chk("en0_errh", errh_cnt, 0);
    en = 1'b1;
    gen_frame(VT, -1, 0);
    chk("f11_lock", fs_locked, 0);
    gen_frame(VT, -1, 0);
    chk("f12_lock", fs_locked, 1);
    chk("f12_pv", pv_cnt, NPIX);

    clear_stats();
    repeat (3000) step(pins_of(6'd0, 1'b0, 1'b0), idle);
    chk("hold_pv", pv_cnt, 0);
    chk("hold_hcount", dut.hcount, 11'h7FF);

    gen_frame(5, -1, 0);
    chk("pre_rst_llen", line_len, HT);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
